// File: rtl/imem_boot_loader.sv
// Byte-stream boot loader: assembles big-endian words, fills instruction memory, then releases
// the CPU. Optional trailing checksum check enabled by defining IMEM_BOOT_CHECKSUM_EN.
module imem_boot_loader #(
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk_i,
    input  logic              rst_n,
    input  logic              load_req_i,
    input  logic [7:0]        byte_i,
    input  logic              byte_valid_i,
    output logic              byte_ready_o,
    output logic              im_we_o,
    output logic [ADDR_W-1:0] im_addr_o,
    output logic [31:0]       im_wdata_o,
    output logic              cpu_rst_n_o,
    output logic              done_o,
    output logic              err_o,
    output logic [ADDR_W:0]   word_cnt_o
);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StWrite,
        StCsum,
        StRun,
        StErr
    } state_e;

    state_e            r_state;
    logic [1:0]        r_idx;
    logic [23:0]       r_shift;
    logic              r_ready;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              r_cpu_rst_n;
    logic              r_done;
    logic              r_err;
    logic [ADDR_W:0]   r_cnt;
`ifdef IMEM_BOOT_CHECKSUM_EN
    logic [31:0]       r_acc;
`endif

    logic        w_xfer;
    logic [31:0] w_word;

    assign w_xfer = r_ready & byte_valid_i;
    assign w_word = {r_shift, byte_i};

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_idx       <= '0;
            r_shift     <= '0;
            r_ready     <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_cpu_rst_n <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_cnt       <= '0;
`ifdef IMEM_BOOT_CHECKSUM_EN
            r_acc       <= '0;
`endif
        end else if (load_req_i) begin
            // Restart wins over everything; an in-flight write strobe already went out this cycle.
            r_state     <= StLoad;
            r_idx       <= '0;
            r_ready     <= 1'b1;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_cpu_rst_n <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_cnt       <= '0;
`ifdef IMEM_BOOT_CHECKSUM_EN
            r_acc       <= '0;
`endif
        end else begin
            case (r_state)
                StLoad: begin
                    if (w_xfer) begin
                        r_shift <= w_word[23:0];
                        r_idx   <= r_idx + 2'd1;
                        if (r_idx == 2'd3) begin
                            r_state <= StWrite;
                            r_ready <= 1'b0;
                            r_we    <= 1'b1;
                            r_wdata <= w_word;
                        end
                    end
                end
                StWrite: begin
                    r_we <= 1'b0;
                    if (r_wdata == 32'd0) begin
`ifdef IMEM_BOOT_CHECKSUM_EN
                        r_state <= StCsum;
                        r_ready <= 1'b1;
                        r_idx   <= '0;
`else
                        r_state     <= StRun;
                        r_cpu_rst_n <= 1'b1;
                        r_done      <= 1'b1;
`endif
                    end else if (r_addr == {ADDR_W{1'b1}}) begin
                        // Last slot used by a non-terminator: no room left for the terminator.
                        r_state <= StErr;
                        r_err   <= 1'b1;
                    end else begin
                        r_state <= StLoad;
                        r_ready <= 1'b1;
                        r_addr  <= r_addr + 1'b1;
                        r_cnt   <= r_cnt + 1'b1;
`ifdef IMEM_BOOT_CHECKSUM_EN
                        r_acc   <= r_acc ^ r_wdata;
`endif
                    end
                end
`ifdef IMEM_BOOT_CHECKSUM_EN
                StCsum: begin
                    if (w_xfer) begin
                        r_shift <= w_word[23:0];
                        r_idx   <= r_idx + 2'd1;
                        if (r_idx == 2'd3) begin
                            r_ready <= 1'b0;
                            if (w_word == r_acc) begin
                                r_state     <= StRun;
                                r_cpu_rst_n <= 1'b1;
                                r_done      <= 1'b1;
                            end else begin
                                r_state <= StErr;
                                r_err   <= 1'b1;
                            end
                        end
                    end
                end
`endif
                default: begin
                    // Idle, Run and Err hold until a load request or reset.
                end
            endcase
        end
    end

    assign byte_ready_o = r_ready;
    assign im_we_o      = r_we;
    assign im_addr_o    = r_addr;
    assign im_wdata_o   = r_wdata;
    assign cpu_rst_n_o  = r_cpu_rst_n;
    assign done_o       = r_done;
    assign err_o        = r_err;
    assign word_cnt_o   = r_cnt;

endmodule
